ex_mem_bridge: RTL and testbench
================================

# ex_mem_bridge

Synthesizable external-memory bridge that sits directly on the ElectronNest load/store ports (`O_Ld_*`/`I_Ld_FTk`, `O_St_*`/`I_St_BTk`). It holds a single-port word memory that a host preloads and, on a boot request, streams a boot frame into the array. It then serves array loads with one-cycle latency and accepts array stores. Stores are nacked when a load collides with them. Optionally, it generates the index field for index-compressed loads.

## Interface
- `DEPTH`, 1024: memory words; valid addresses are 0..DEPTH-1.
- `BOOT_PAD`, 3: zero-data valid words sent before the program words.
- `BOOT_LEN`, 5: program words sent from mem[0..BOOT_LEN-1].
- `IDX_CLR_ADDR0`, 16'h0190: load address that clears the index counter.
- `IDX_CLR_ADDR1`, 16'h0290: second clearing address.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: reset is synchronous and active-low.
- `I_Init_We` in 1: host preload write enable. Honoured only in IDLE.
- `I_Init_Addr` in WIDTH_EXADDR: host preload address.
- `I_Init_Data` in WIDTH_DATA: host preload data.
- `I_Boot` in 1: boot request, level-sampled in IDLE.
- `O_Boot` out 1: high for the whole boot frame; drives the array's `I_Boot`.
- `O_Boot_Done` out 1: sticky high once in RUN.
- `I_Ld_Req` in 1: array load request.
- `I_Ld_Addr` in WIDTH_EXADDR: load address.
- `O_Ld_FTk` out FTk_t: load data token to the array.
- `I_Ld_BTk` in BTk_t: load back token; `.t` terminates the index run.
- `I_St_Req` in 1: array store request.
- `I_St_Addr` in WIDTH_EXADDR: store address.
- `I_St_FTk` in FTk_t: store data token.
- `O_St_BTk` out BTk_t: store back token; only `.n` is ever driven non-zero.

## Operation
- States: IDLE, BOOT_PAD, BOOT_PROG, RUN.
- IDLE:
  - Host writes land in memory when `I_Init_We` is high and the address is in range.
  - `I_Boot`=1 moves to BOOT_PAD with the boot counter at 0.
- BOOT_PAD: emits BOOT_PAD tokens with v=1, d=0, i=0.
  - The first boot token carries a=1; all other tokens carry a=0.
  - After BOOT_PAD tokens, moves to BOOT_PROG.
- BOOT_PROG: emits BOOT_LEN tokens with v=1, d=mem[k] for k=0..BOOT_LEN-1.
  - After the last token, moves to RUN.
- RUN: terminal state; only reset leaves it.
  - Load: `I_Ld_Req`=1 -> next cycle `O_Ld_FTk` has v=1 and d=mem[I_Ld_Addr]. Out-of-range addresses return d=0.
  - In any other cycle, v=0; d holds the last value.
  - a, r and c are always 0 in RUN.
  - Store commits when `I_St_Req & I_St_FTk.v & ~O_St_BTk.n`. Out-of-range stores are silently dropped.
  - `O_St_BTk.n` is combinational: 1 when `I_St_Req & I_Ld_Req` (load wins the single port). The array retries the store.
  - `O_St_BTk.n`=1 whenever the state is not RUN.
- Load requests outside RUN are ignored.
- `O_Boot` = (state is BOOT_PAD or BOOT_PROG).

## Timing
- Reset values:
  - state=IDLE, boot counter=0, index counter=0.
  - `O_Ld_FTk`=all zero, `O_Boot`=0, `O_Boot_Done`=0.
  - `O_St_BTk`: n=1 (state is IDLE); all other fields 0.
  - Memory contents are not reset.
- Reset mid-boot or mid-RUN: returns to IDLE at the next edge. Memory is retained, so a new `I_Boot` replays the boot frame.
- Boot frame: BOOT_PAD+BOOT_LEN consecutive v=1 cycles, starting the cycle after `I_Boot` is sampled. `O_Boot_Done` rises on the cycle RUN is entered.
- Load latency: exactly 1 cycle. Back-to-back requests produce back-to-back tokens.
- A store followed by a load of the same address in the next cycle returns the new data. Write-first; no bypass is needed because the store has already committed.

## Configuration
- `EXMEM_IDX_COMP_EN` defined: `O_Ld_FTk.i` carries the index counter.
  - Token i = 0 if mem[addr]==1, else the index counter value.
  - Counter update priority, highest first:
    - I_Ld_Addr == IDX_CLR_ADDR0 or IDX_CLR_ADDR1 -> 0.
    - `I_Ld_BTk.t` -> 0.
    - Served load -> 1 if mem[addr]==1, else counter+1.
  - Counter is 8 bits and wraps 255->0.
- Undefined: i=0 always. The counter logic is absent.

## Test plan
- Preload mem[0..4]=1,2,3,4,5 and pulse `I_Boot` -> 8 valid tokens: d=0,0,0,1,2,3,4,5. a=1 only on the first. `O_Boot` high for 8 cycles. `O_Boot_Done`=1 on the next cycle.
- RUN: load addr 10 with mem[10]=0xABCD -> next cycle v=1, d=0xABCD. Idle cycle -> v=0.
- Store 0x55 to addr 20 with no load -> n=0 and commit. Next-cycle load of 20 -> d=0x55.
- Simultaneous load addr 5 and store addr 6 -> n=1 and store dropped. Load returns mem[5]. Store retry next cycle commits.
- `EXMEM_IDX_COMP_EN`, data 1,7,8,9,1,4 at consecutive addresses -> i=0,1,2,3,0,1. Load of 16'h0190 resets the counter; the next load gets i=0.
- Assert reset during BOOT_PROG -> next edge: IDLE, `O_Ld_FTk`=0, `O_Boot`=0. Re-boot replays the full 8-token frame.

Source files
------------

// File: rtl/ex_mem_bridge_if.sv
// Load/store port bundle between the ElectronNest array (master) and ex_mem_bridge (slave).
// Also carries host preload and boot signals, and the forward/back token types.
interface ex_mem_bridge_if #(
    parameter int unsigned WIDTH_EXADDR = 16,
    parameter int unsigned WIDTH_DATA   = 16
);
    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic                  c;
        logic [7:0]            i;
        logic [WIDTH_DATA-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic n;
        logic t;
    } BTk_t;

    logic                    I_Init_We;
    logic [WIDTH_EXADDR-1:0] I_Init_Addr;
    logic [WIDTH_DATA-1:0]   I_Init_Data;
    logic                    I_Boot;
    logic                    O_Boot;
    logic                    O_Boot_Done;
    logic                    I_Ld_Req;
    logic [WIDTH_EXADDR-1:0] I_Ld_Addr;
    FTk_t                    O_Ld_FTk;
    BTk_t                    I_Ld_BTk;
    logic                    I_St_Req;
    logic [WIDTH_EXADDR-1:0] I_St_Addr;
    FTk_t                    I_St_FTk;
    BTk_t                    O_St_BTk;

    modport slave (
        input  I_Init_We, I_Init_Addr, I_Init_Data, I_Boot,
        input  I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
        input  I_St_Req, I_St_Addr, I_St_FTk,
        output O_Boot, O_Boot_Done, O_Ld_FTk, O_St_BTk
    );

    modport master (
        output I_Init_We, I_Init_Addr, I_Init_Data, I_Boot,
        output I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
        output I_St_Req, I_St_Addr, I_St_FTk,
        input  O_Boot, O_Boot_Done, O_Ld_FTk, O_St_BTk
    );
endinterface

// File: rtl/ex_mem_bridge.sv
// External-memory bridge: host preload, boot-frame streaming, then 1-cycle loads / nackable stores.
// Define EXMEM_IDX_COMP_EN to generate the index field of index-compressed loads.
module ex_mem_bridge #(
    parameter int unsigned             WIDTH_EXADDR  = 16,
    parameter int unsigned             WIDTH_DATA    = 16,
    parameter int unsigned             DEPTH         = 1024,
    parameter int unsigned             BOOT_PAD      = 3,
    parameter int unsigned             BOOT_LEN      = 5,
    parameter logic [WIDTH_EXADDR-1:0] IDX_CLR_ADDR0 = 16'h0190,
    parameter logic [WIDTH_EXADDR-1:0] IDX_CLR_ADDR1 = 16'h0290
) (
    input  logic           clock,
    input  logic           reset,
    ex_mem_bridge_if.slave bus
);
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FRAME = BOOT_PAD + BOOT_LEN;
    localparam int unsigned BCW   = (FRAME > 0) ? $clog2(FRAME + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BOOT_PAD, S_BOOT_PROG, S_RUN} state_t;

    logic [WIDTH_DATA-1:0]   mem [DEPTH];

    state_t                  state_q, state_d;
    logic [BCW-1:0]          bcnt_q, bcnt_d;
    logic [BCW-1:0]          prog_idx;
    logic                    done_q;

    logic                    ftk_v_q, ftk_v_d;
    logic                    ftk_a_q, ftk_a_d;
    logic [7:0]              ftk_i_q, ftk_i_d;
    logic [WIDTH_DATA-1:0]   ftk_d_q, ftk_d_d;

    logic [WIDTH_EXADDR-1:0] rd_addr;
    logic [WIDTH_DATA-1:0]   rd_data;
    logic                    st_nack;
    logic                    st_commit;
    logic                    init_commit;
    logic [7:0]              idx_tok;
    logic                    unused_fields;

    assign unused_fields = ^{bus.I_Ld_BTk, bus.I_St_FTk};

    // Single read port: boot walks mem[0..BOOT_LEN-1], RUN follows the load address.
    always_comb begin
        prog_idx = bcnt_d - BCW'(BOOT_PAD);
        rd_addr  = (state_q == S_RUN) ? bus.I_Ld_Addr : WIDTH_EXADDR'(prog_idx);
        rd_data  = (32'(rd_addr) < DEPTH) ? mem[rd_addr[AW-1:0]] : '0;
    end

    always_comb begin
        st_nack     = (state_q != S_RUN) || (bus.I_St_Req && bus.I_Ld_Req);
        st_commit   = (state_q == S_RUN) && bus.I_St_Req && bus.I_St_FTk.v && !st_nack
                      && (32'(bus.I_St_Addr) < DEPTH);
        init_commit = (state_q == S_IDLE) && bus.I_Init_We && (32'(bus.I_Init_Addr) < DEPTH);
    end

    always_ff @(posedge clock) begin
        if (init_commit) begin
            mem[bus.I_Init_Addr[AW-1:0]] <= bus.I_Init_Data;
        end else if (st_commit) begin
            mem[bus.I_St_Addr[AW-1:0]] <= bus.I_St_FTk.d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            done_q  <= 1'b0;
            ftk_v_q <= 1'b0;
            ftk_a_q <= 1'b0;
            ftk_i_q <= '0;
            ftk_d_q <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            done_q  <= done_q || (state_d == S_RUN);
            ftk_v_q <= ftk_v_d;
            ftk_a_q <= ftk_a_d;
            ftk_i_q <= ftk_i_d;
            ftk_d_q <= ftk_d_d;
        end
    end

    // bcnt is the position within the whole frame, so it runs through pad and program words.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.I_Boot) begin
                    bcnt_d  = '0;
                    state_d = (BOOT_PAD != 0) ? S_BOOT_PAD :
                              (BOOT_LEN != 0) ? S_BOOT_PROG : S_RUN;
                end
            end
            S_BOOT_PAD: begin
                bcnt_d = bcnt_q + BCW'(1);
                if (bcnt_q == BCW'(BOOT_PAD - 1)) begin
                    state_d = (BOOT_LEN != 0) ? S_BOOT_PROG : S_RUN;
                end
            end
            S_BOOT_PROG: begin
                bcnt_d = bcnt_q + BCW'(1);
                if (bcnt_q == BCW'(FRAME - 1)) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // The token register is loaded with the token for the state being entered, so the
    // first boot token appears in the cycle right after I_Boot is sampled.
    always_comb begin
        ftk_v_d = 1'b0;
        ftk_a_d = 1'b0;
        ftk_i_d = ftk_i_q;
        ftk_d_d = ftk_d_q;
        case (state_d)
            S_BOOT_PAD: begin
                ftk_v_d = 1'b1;
                ftk_a_d = (bcnt_d == '0);
                ftk_i_d = '0;
                ftk_d_d = '0;
            end
            S_BOOT_PROG: begin
                ftk_v_d = 1'b1;
                ftk_a_d = (bcnt_d == '0);
                ftk_i_d = '0;
                ftk_d_d = rd_data;
            end
            S_RUN: begin
                if ((state_q == S_RUN) && bus.I_Ld_Req) begin
                    ftk_v_d = 1'b1;
                    ftk_i_d = idx_tok;
                    ftk_d_d = rd_data;
                end
            end
            default: begin
                ftk_i_d = '0;
                ftk_d_d = '0;
            end
        endcase

        bus.O_Ld_FTk    = {ftk_v_q, ftk_a_q, 1'b0, 1'b0, ftk_i_q, ftk_d_q};
        bus.O_St_BTk    = {st_nack, 1'b0};
        bus.O_Boot      = (state_q == S_BOOT_PAD) || (state_q == S_BOOT_PROG);
        bus.O_Boot_Done = done_q;
    end

`ifdef EXMEM_IDX_COMP_EN
    logic [7:0] idx_q, idx_d;
    logic       ld_clr;

    always_comb begin
        ld_clr  = bus.I_Ld_Req && ((bus.I_Ld_Addr == IDX_CLR_ADDR0) ||
                                   (bus.I_Ld_Addr == IDX_CLR_ADDR1));
        idx_tok = (rd_data == WIDTH_DATA'(1)) ? 8'd0 : idx_q;
        idx_d   = idx_q;
        if (state_q == S_RUN) begin
            if (ld_clr || bus.I_Ld_BTk.t) begin
                idx_d = '0;
            end else if (bus.I_Ld_Req) begin
                idx_d = (rd_data == WIDTH_DATA'(1)) ? 8'd1 : idx_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end
`else
    assign idx_tok = '0;
`endif
endmodule

// File: tb/tb_ex_mem_bridge.sv
// Self-checking bench for ex_mem_bridge: directed boot/load/store/reset steps plus
// randomized RUN traffic checked against an array-based memory model.
module tb_ex_mem_bridge;
    localparam int unsigned DEPTH = 1024;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    ex_mem_bridge_if #(.WIDTH_EXADDR(16), .WIDTH_DATA(16)) bus ();

    ex_mem_bridge #(
        .WIDTH_EXADDR(16),
        .WIDTH_DATA(16),
        .DEPTH(DEPTH),
        .BOOT_PAD(3),
        .BOOT_LEN(5)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [15:0] mdl [DEPTH];
    logic [7:0]  idx_m  = 8'd0;
    logic [15:0] last_d = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.I_Init_We   = 1'b0;
        bus.I_Init_Addr = 16'd0;
        bus.I_Init_Data = 16'd0;
        bus.I_Boot      = 1'b0;
        bus.I_Ld_Req    = 1'b0;
        bus.I_Ld_Addr   = 16'd0;
        bus.I_Ld_BTk    = '0;
        bus.I_St_Req    = 1'b0;
        bus.I_St_Addr   = 16'd0;
        bus.I_St_FTk    = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return (32'(a) < DEPTH) ? mdl[a[9:0]] : 16'h0000;
    endfunction

    // One RUN cycle: predict from the model, clock, compare the token.
    task automatic run_cycle(input logic ld, input logic [15:0] la, input logic st,
                             input logic [15:0] sa, input logic sv, input logic [15:0] sd,
                             input logic t);
        logic [15:0] exp_d;
        logic [7:0]  exp_i;
        logic        nack;
        bus.I_Ld_Req   = ld;
        bus.I_Ld_Addr  = la;
        bus.I_Ld_BTk.t = t;
        bus.I_St_Req   = st;
        bus.I_St_Addr  = sa;
        bus.I_St_FTk.v = sv;
        bus.I_St_FTk.d = sd;
        #1;
        nack = ld & st;
        chk("st_nack", bus.O_St_BTk, {nack, 1'b0});
        exp_d = mem_rd(la);
        exp_i = 8'd0;
`ifdef EXMEM_IDX_COMP_EN
        if (ld) exp_i = (exp_d == 16'd1) ? 8'd0 : idx_m;
        if (ld && (la == 16'h0190 || la == 16'h0290)) idx_m = 8'd0;
        else if (t) idx_m = 8'd0;
        else if (ld) idx_m = (exp_d == 16'd1) ? 8'd1 : idx_m + 8'd1;
`endif
        if (st && sv && !nack && 32'(sa) < DEPTH) mdl[sa[9:0]] = sd;
        tick();
        chk("ld_v", bus.O_Ld_FTk.v, ld);
        if (ld) last_d = exp_d;
        chk("ld_d", bus.O_Ld_FTk.d, last_d);
        if (ld) chk("ld_i", bus.O_Ld_FTk.i, exp_i);
        chk("ld_arc", {bus.O_Ld_FTk.a, bus.O_Ld_FTk.r, bus.O_Ld_FTk.c}, 3'b000);
        chk("boot_done_run", bus.O_Boot_Done, 1'b1);
        idle_inputs();
    endtask

    // Boot frame; a reset is applied while token abort_at is on the bus (>=8: full frame).
    task automatic boot_frame(input int unsigned abort_at);
        logic [15:0] exp_d;
        bus.I_Boot = 1'b1;
        tick();
        bus.I_Boot      = 1'b0;
        bus.I_Ld_Req    = 1'b1;
        bus.I_Ld_Addr   = 16'd10;
        bus.I_St_Req    = 1'b1;
        bus.I_St_FTk.v  = 1'b1;
        bus.I_Init_We   = 1'b1;
        bus.I_Init_Addr = 16'd1;
        bus.I_Init_Data = 16'hDEAD;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k == abort_at) begin
                reset = 1'b0;
                tick();
                chk("rst_ftk", bus.O_Ld_FTk, 32'd0);
                chk("rst_boot", bus.O_Boot, 1'b0);
                chk("rst_done", bus.O_Boot_Done, 1'b0);
                chk("rst_stbtk", bus.O_St_BTk, 2'b10);
                reset = 1'b1;
                idle_inputs();
                idx_m  = 8'd0;
                last_d = 16'd0;
                return;
            end
            exp_d = (k < 3) ? 16'h0000 : mdl[10'(k - 3)];
            chk("boot_n", bus.O_St_BTk.n, 1'b1);
            chk("boot_v", bus.O_Ld_FTk.v, 1'b1);
            chk("boot_a", bus.O_Ld_FTk.a, (k == 0));
            chk("boot_d", bus.O_Ld_FTk.d, exp_d);
            chk("boot_i", bus.O_Ld_FTk.i, 8'd0);
            chk("boot_o", bus.O_Boot, 1'b1);
            chk("boot_done", bus.O_Boot_Done, 1'b0);
            tick();
        end
        last_d = mdl[4];
        chk("run_done", bus.O_Boot_Done, 1'b1);
        chk("run_boot", bus.O_Boot, 1'b0);
        chk("run_v", bus.O_Ld_FTk.v, 1'b0);
        chk("run_d_hold", bus.O_Ld_FTk.d, last_d);
        idle_inputs();
    endtask

    initial begin
        logic [15:0] sa, la;
        idle_inputs();
        tick();
        tick();
        chk("reset_ftk", bus.O_Ld_FTk, 32'd0);
        chk("reset_boot", bus.O_Boot, 1'b0);
        chk("reset_done", bus.O_Boot_Done, 1'b0);
        chk("reset_stbtk", bus.O_St_BTk, 2'b10);
        reset = 1'b1;

        for (int unsigned a = 0; a < DEPTH; a++) mdl[a] = 16'($urandom);
        for (int unsigned a = 0; a < 5; a++) mdl[a] = 16'(a + 1);
        mdl[10] = 16'hABCD;
        mdl[100] = 16'd1; mdl[101] = 16'd7; mdl[102] = 16'd8;
        mdl[103] = 16'd9; mdl[104] = 16'd1; mdl[105] = 16'd4;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            bus.I_Init_We   = 1'b1;
            bus.I_Init_Addr = 16'(a);
            bus.I_Init_Data = mdl[a];
            tick();
        end
        bus.I_Init_Addr = 16'(DEPTH + 7);
        bus.I_Init_Data = ~mdl[7];
        tick();
        idle_inputs();
        bus.I_St_Req = 1'b1;
        #1;
        chk("idle_nack", bus.O_St_BTk.n, 1'b1);
        idle_inputs();

        boot_frame(99);

        run_cycle(1, 16'd10, 0, 16'd0, 0, 16'd0, 0);
        chk("load_abcd", bus.O_Ld_FTk.d, 16'hABCD);
        run_cycle(0, 16'd0, 0, 16'd0, 0, 16'd0, 0);
        run_cycle(0, 16'd0, 1, 16'd20, 1, 16'h0055, 0);
        run_cycle(1, 16'd20, 0, 16'd0, 0, 16'd0, 0);
        chk("store_then_load", bus.O_Ld_FTk.d, 16'h0055);
        run_cycle(1, 16'd5, 1, 16'd6, 1, 16'h1234, 0);
        run_cycle(0, 16'd0, 1, 16'd6, 1, 16'h1234, 0);
        run_cycle(1, 16'd6, 0, 16'd0, 0, 16'd0, 0);
        chk("store_retry", bus.O_Ld_FTk.d, 16'h1234);
        run_cycle(1, 16'hFFFF, 0, 16'd0, 0, 16'd0, 0);
        chk("load_oor", bus.O_Ld_FTk.d, 16'h0000);
        run_cycle(1, 16'(DEPTH), 0, 16'd0, 0, 16'd0, 0);
        run_cycle(0, 16'd0, 1, 16'(DEPTH + 20), 1, 16'hBEEF, 0);
        run_cycle(1, 16'd20, 0, 16'd0, 0, 16'd0, 0);
        run_cycle(1, 16'd7, 0, 16'd0, 0, 16'd0, 0);
        run_cycle(0, 16'd0, 1, 16'd9, 0, 16'hCAFE, 0);
        run_cycle(1, 16'd9, 0, 16'd0, 0, 16'd0, 0);

        bus.I_Init_We   = 1'b1;
        bus.I_Init_Addr = 16'd30;
        bus.I_Init_Data = ~mdl[30];
        run_cycle(0, 16'd0, 0, 16'd0, 0, 16'd0, 0);
        run_cycle(1, 16'd30, 0, 16'd0, 0, 16'd0, 0);

        run_cycle(1, 16'h0190, 0, 16'd0, 0, 16'd0, 0);
        for (int unsigned a = 100; a < 106; a++) run_cycle(1, 16'(a), 0, 16'd0, 0, 16'd0, 0);
        run_cycle(1, 16'h0290, 0, 16'd0, 0, 16'd0, 0);
        run_cycle(1, 16'd101, 0, 16'd0, 0, 16'd0, 0);
        run_cycle(1, 16'd102, 0, 16'd0, 0, 16'd0, 0);
        run_cycle(0, 16'd0, 0, 16'd0, 0, 16'd0, 1);
        run_cycle(1, 16'd103, 0, 16'd0, 0, 16'd0, 0);

        for (int n = 0; n < 300; n++) begin
            la = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(DEPTH, DEPTH + 80))
                                             : 16'($urandom_range(0, 63));
            sa = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(DEPTH, DEPTH + 80))
                                             : 16'($urandom_range(0, 63));
            run_cycle(1'($urandom_range(0, 1)), la, 1'($urandom_range(0, 1)), sa,
                      1'($urandom_range(0, 3) != 0), 16'($urandom),
                      1'($urandom_range(0, 15) == 0));
        end

        reset = 1'b0;
        tick();
        chk("rst_run_ftk", bus.O_Ld_FTk, 32'd0);
        chk("rst_run_done", bus.O_Boot_Done, 1'b0);
        chk("rst_run_n", bus.O_St_BTk.n, 1'b1);
        reset  = 1'b1;
        idx_m  = 8'd0;
        last_d = 16'd0;

        boot_frame(5);
        boot_frame(99);
        for (int unsigned a = 0; a < 8; a++) run_cycle(1, 16'(a), 0, 16'd0, 0, 16'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
